dmem_arbiter: RTL and testbench

//  Shares the single-port word-addressed data memory between two requesters:
//  req 0 = core load/store unit, req 1 = DMA/debug port. Arbitration is

---
 rtl/dmem_arbiter_if.sv | 31 +++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-pin bundle shared by the data-memory arbiter and its environment.
// Per-requester fields are packed side by side: requester i owns slice i.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_we;
    logic [7:0]          req_be;
    logic [2*ADDR_W-1:0] req_addr;
    logic [63:0]         req_wdata;
    logic [1:0]          rsp_valid;
    logic [63:0]         rsp_rdata;
    logic                mem_wr_en;
    logic                mem_read_en;
    logic [ADDR_W-1:0]   mem_address;
    logic [31:0]         mem_write_data;
    logic [31:0]         mem_read_data;

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, mem_read_data,
        output req_ready, rsp_valid, rsp_rdata,
               mem_wr_en, mem_read_en, mem_address, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata,
               mem_wr_en, mem_read_en, mem_address, mem_write_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port, whole-word data memory.
// Partial-byte stores become a read cycle followed by a write of the merged word.
module dmem_arbiter #(
    parameter bit RR_EN  = 1'b1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clock,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam int LANES = DATA_W / 8;

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t              r_state;
    logic                r_lastGrant;
    logic                r_rmwGrant;
    logic [ADDR_W-3:0]   r_addrHi;
    logic [DATA_W-1:0]   r_merge;
    logic [1:0]          r_rspValid;
    logic [63:0]         r_rspRdata;

    logic                w_grant;
    logic                w_accept;
    logic                w_we;
    logic [3:0]          w_be;
    logic [ADDR_W-3:0]   w_addrHi;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_load;
    logic                w_full;
    logic                w_partial;
    logic [DATA_W-1:0]   w_merged;

    // On a tie the round-robin pointer favours whoever did not win last time.
    always_comb begin
        w_grant = 1'b0;
        if (bus.req_valid == 2'b11) begin
            w_grant = RR_EN ? ~r_lastGrant : 1'b0;
        end else begin
            w_grant = ~bus.req_valid[0];
        end
    end

    assign w_accept  = (r_state == IDLE) && !reset && (|bus.req_valid);
    assign w_we      = bus.req_we[w_grant];
    assign w_be      = bus.req_be[{w_grant, 2'b00} +: 4];
    assign w_wdata   = bus.req_wdata[{w_grant, 5'b00000} +: 32];
    assign w_addrHi  = w_grant ? bus.req_addr[2*ADDR_W-1:ADDR_W+2] : bus.req_addr[ADDR_W-1:2];
    assign w_load    = !w_we;
    assign w_full    = w_we && (w_be == 4'hF);
    assign w_partial = w_we && (w_be != 4'h0) && (w_be != 4'hF);

    always_comb begin
        w_merged = '0;
        for (int i = 0; i < LANES; i++) begin
            w_merged[8*i +: 8] = w_be[i] ? w_wdata[8*i +: 8] : bus.mem_read_data[8*i +: 8];
        end
    end

    // Memory pins follow the winner in the accept cycle; the RMW cycle replays the merged word.
    always_comb begin
        bus.req_ready      = 2'b00;
        bus.mem_wr_en      = 1'b0;
        bus.mem_read_en    = 1'b0;
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        if (!reset) begin
            if (r_state == RMW_WR) begin
                bus.mem_wr_en      = 1'b1;
                bus.mem_address    = {r_addrHi, 2'b00};
                bus.mem_write_data = r_merge;
            end else if (|bus.req_valid) begin
                bus.req_ready = w_grant ? 2'b10 : 2'b01;
                if (w_load || w_partial) begin
                    bus.mem_read_en = 1'b1;
                    bus.mem_address = {w_addrHi, 2'b00};
                end else if (w_full) begin
                    bus.mem_wr_en      = 1'b1;
                    bus.mem_address    = {w_addrHi, 2'b00};
                    bus.mem_write_data = w_wdata;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_lastGrant <= 1'b1;
            r_rmwGrant  <= 1'b0;
            r_addrHi    <= '0;
            r_merge     <= '0;
            r_rspValid  <= 2'b00;
            r_rspRdata  <= '0;
        end else begin
            r_rspValid <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_lastGrant <= w_grant;
                        if (w_partial) begin
                            r_merge    <= w_merged;
                            r_addrHi   <= w_addrHi;
                            r_rmwGrant <= w_grant;
                            r_state    <= RMW_WR;
                        end else begin
                            r_rspValid[w_grant] <= 1'b1;
                            r_rspRdata[{w_grant, 5'b00000} +: 32] <= w_load ? bus.mem_read_data : 32'h0;
                        end
                    end
                end
                RMW_WR: begin
                    r_rspValid[r_rmwGrant] <= 1'b1;
                    r_rspRdata[{r_rmwGrant, 5'b00000} +: 32] <= 32'h0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_rdata = r_rspRdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one round-robin and one fixed-priority instance, each with a 16-word memory.
// Directed scenarios first, then random traffic checked against a transaction-level model.
module tb_dmem_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic memInit = 1'b1;

    dmem_arbiter_if #(.ADDR_W(32)) busA ();
    dmem_arbiter_if #(.ADDR_W(32)) busB ();

    dmem_arbiter #(.RR_EN(1'b1), .ADDR_W(32), .DATA_W(32)) dutA (.clock(clock), .reset(reset), .bus(busA));
    dmem_arbiter #(.RR_EN(1'b0), .ADDR_W(32), .DATA_W(32)) dutB (.clock(clock), .reset(reset), .bus(busB));

    logic [31:0] initA [16];
    logic [31:0] initB [16];
    logic [31:0] memA  [16];
    logic [31:0] memB  [16];
    logic [31:0] refA  [16];
    logic [31:0] refB  [16];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Environment memories: combinational read, write on the clock edge.
    assign busA.mem_read_data = memA[busA.mem_address[5:2]];
    assign busB.mem_read_data = memB[busB.mem_address[5:2]];

    always @(posedge clock) begin
        if (memInit) begin
            for (int i = 0; i < 16; i++) begin
                memA[i] <= initA[i];
                memB[i] <= initB[i];
            end
        end else begin
            if (busA.mem_wr_en) memA[busA.mem_address[5:2]] <= busA.mem_write_data;
            if (busB.mem_wr_en) memB[busB.mem_address[5:2]] <= busB.mem_write_data;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic driveReq(input bit sel, input int r, input logic v, input logic we,
                            input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
        if (!sel) begin
            busA.req_valid[r]         = v;
            busA.req_we[r]            = we;
            busA.req_be[r*4 +: 4]     = be;
            busA.req_addr[r*32 +: 32] = addr;
            busA.req_wdata[r*32 +: 32] = wd;
        end else begin
            busB.req_valid[r]         = v;
            busB.req_we[r]            = we;
            busB.req_be[r*4 +: 4]     = be;
            busB.req_addr[r*32 +: 32] = addr;
            busB.req_wdata[r*32 +: 32] = wd;
        end
    endtask

    task automatic idleAll();
        busA.req_valid = 2'b00; busA.req_we = 2'b00; busA.req_be = 8'h00;
        busA.req_addr = '0; busA.req_wdata = '0;
        busB.req_valid = 2'b00; busB.req_we = 2'b00; busB.req_be = 8'h00;
        busB.req_addr = '0; busB.req_wdata = '0;
    endtask

    function automatic logic [31:0] randWordAddr();
        logic [3:0] w;
        w = 4'($urandom_range(0, 15));
        return {26'd0, w, 2'b00};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        idleAll();
        driveReq(0, 0, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        driveReq(0, 1, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        repeat (2) begin
            @(posedge clock); #1;
            checks++;
            if (busA.req_ready !== 2'b00) begin
                errors++; $display("[TB] FAIL reset_ready got %b want 00", busA.req_ready);
            end
            checks++;
            if (busA.rsp_valid !== 2'b00 || busA.rsp_rdata !== 64'h0) begin
                errors++; $display("[TB] FAIL reset_rsp got v=%b d=%h want 0", busA.rsp_valid, busA.rsp_rdata);
            end
            checks++;
            if ({busA.mem_wr_en, busA.mem_read_en} !== 2'b00 || busA.mem_address !== 32'h0 ||
                busA.mem_write_data !== 32'h0) begin
                errors++; $display("[TB] FAIL reset_mem got we=%b re=%b a=%h d=%h want 0",
                                   busA.mem_wr_en, busA.mem_read_en, busA.mem_address, busA.mem_write_data);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (busA.req_ready !== 2'b01) begin
            errors++; $display("[TB] FAIL first_grant got %b want 01", busA.req_ready);
        end
        checks++;
        if (busA.mem_read_en !== 1'b1 || busA.mem_address !== 32'h4) begin
            errors++; $display("[TB] FAIL first_read got re=%b a=%h want 1/4", busA.mem_read_en, busA.mem_address);
        end
        @(posedge clock); #1;
        checks++;
        if (busA.rsp_valid !== 2'b01 || busA.rsp_rdata[31:0] !== refA[1]) begin
            errors++; $display("[TB] FAIL first_rsp got v=%b d=%h want 01/%h", busA.rsp_valid, busA.rsp_rdata[31:0], refA[1]);
        end
        @(negedge clock);
        idleAll();
    endtask

    task automatic test_alternate();
        logic [31:0] a [2];
        int expG;
        logic [1:0] eRdy;
        @(negedge clock); reset = 1'b1; idleAll();
        @(negedge clock); reset = 1'b0;
        a[0] = randWordAddr();
        a[1] = randWordAddr();
        expG = 0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clock);
            driveReq(0, 0, 1'b1, 1'b0, 4'hF, a[0], 32'h0);
            driveReq(0, 1, 1'b1, 1'b0, 4'hF, a[1], 32'h0);
            eRdy = (expG == 0) ? 2'b01 : 2'b10;
            #1;
            checks++;
            if (busA.req_ready !== eRdy) begin
                errors++; $display("[TB] FAIL alt_grant k=%0d got %b want %b", k, busA.req_ready, eRdy);
            end
            checks++;
            if (busA.mem_read_en !== 1'b1 || busA.mem_wr_en !== 1'b0 || busA.mem_address !== a[expG]) begin
                errors++; $display("[TB] FAIL alt_read k=%0d got re=%b we=%b a=%h want 1/0/%h",
                                   k, busA.mem_read_en, busA.mem_wr_en, busA.mem_address, a[expG]);
            end
            @(posedge clock); #1;
            checks++;
            if (busA.rsp_valid !== eRdy || busA.rsp_rdata[expG*32 +: 32] !== refA[a[expG][5:2]]) begin
                errors++; $display("[TB] FAIL alt_rsp k=%0d got v=%b d=%h want %b/%h",
                                   k, busA.rsp_valid, busA.rsp_rdata[expG*32 +: 32], eRdy, refA[a[expG][5:2]]);
            end
            a[expG] = randWordAddr();
            expG = 1 - expG;
        end
        @(negedge clock);
        idleAll();
    endtask

    task automatic test_store_load();
        driveReq(0, 0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        #1;
        checks++;
        if (busA.req_ready !== 2'b01 || busA.mem_wr_en !== 1'b1 || busA.mem_read_en !== 1'b0 ||
            busA.mem_address !== 32'h10 || busA.mem_write_data !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL st_write got rdy=%b we=%b re=%b a=%h d=%h want 01/1/0/10/deadbeef",
                               busA.req_ready, busA.mem_wr_en, busA.mem_read_en, busA.mem_address, busA.mem_write_data);
        end
        @(posedge clock); #1;
        checks++;
        if (busA.rsp_valid !== 2'b01 || busA.rsp_rdata[31:0] !== 32'h0 || memA[4] !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL st_rsp got v=%b d=%h mem=%h want 01/0/deadbeef",
                               busA.rsp_valid, busA.rsp_rdata[31:0], memA[4]);
        end
        refA[4] = 32'hDEADBEEF;
        @(negedge clock);
        driveReq(0, 0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        #1;
        checks++;
        if (busA.mem_read_en !== 1'b1 || busA.mem_address !== 32'h10) begin
            errors++; $display("[TB] FAIL ld_read got re=%b a=%h want 1/10", busA.mem_read_en, busA.mem_address);
        end
        @(posedge clock); #1;
        checks++;
        if (busA.rsp_valid !== 2'b01 || busA.rsp_rdata[31:0] !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL ld_rsp got v=%b d=%h want 01/deadbeef", busA.rsp_valid, busA.rsp_rdata[31:0]);
        end
        @(negedge clock);
        idleAll();
    endtask

    task automatic test_rmw();
        driveReq(0, 0, 1'b1, 1'b1, 4'b0010, 32'h10, 32'h0000AA00);
        #1;
        checks++;
        if (busA.req_ready !== 2'b01 || busA.mem_read_en !== 1'b1 || busA.mem_wr_en !== 1'b0 ||
            busA.mem_address !== 32'h10) begin
            errors++; $display("[TB] FAIL rmw_read got rdy=%b re=%b we=%b a=%h want 01/1/0/10",
                               busA.req_ready, busA.mem_read_en, busA.mem_wr_en, busA.mem_address);
        end
        @(posedge clock); #1;
        checks++;
        if (busA.rsp_valid !== 2'b00) begin
            errors++; $display("[TB] FAIL rmw_early_rsp got %b want 00", busA.rsp_valid);
        end
        @(negedge clock);
        idleAll();
        driveReq(0, 1, 1'b1, 1'b0, 4'hF, 32'h11, 32'h0);
        #1;
        checks++;
        if (busA.req_ready !== 2'b00) begin
            errors++; $display("[TB] FAIL rmw_ready got %b want 00", busA.req_ready);
        end
        checks++;
        if (busA.mem_wr_en !== 1'b1 || busA.mem_read_en !== 1'b0 || busA.mem_address !== 32'h10 ||
            busA.mem_write_data !== 32'hDEADAAEF) begin
            errors++; $display("[TB] FAIL rmw_write got we=%b re=%b a=%h d=%h want 1/0/10/deadaaef",
                               busA.mem_wr_en, busA.mem_read_en, busA.mem_address, busA.mem_write_data);
        end
        @(posedge clock); #1;
        checks++;
        if (busA.rsp_valid !== 2'b01 || busA.rsp_rdata[31:0] !== 32'h0 || memA[4] !== 32'hDEADAAEF) begin
            errors++; $display("[TB] FAIL rmw_rsp got v=%b d=%h mem=%h want 01/0/deadaaef",
                               busA.rsp_valid, busA.rsp_rdata[31:0], memA[4]);
        end
        refA[4] = 32'hDEADAAEF;
        #3;
        checks++;
        if (busA.req_ready !== 2'b10 || busA.mem_read_en !== 1'b1 || busA.mem_address !== 32'h10) begin
            errors++; $display("[TB] FAIL rmw_next_grant got rdy=%b re=%b a=%h want 10/1/10",
                               busA.req_ready, busA.mem_read_en, busA.mem_address);
        end
        @(posedge clock); #1;
        checks++;
        if (busA.rsp_valid !== 2'b10 || busA.rsp_rdata[63:32] !== 32'hDEADAAEF) begin
            errors++; $display("[TB] FAIL rmw_readback got v=%b d=%h want 10/deadaaef", busA.rsp_valid, busA.rsp_rdata[63:32]);
        end
        @(negedge clock);
        idleAll();
    endtask

    task automatic test_fixed_priority();
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] wd;
        logic [31:0] eD;
        int typ;
        a1 = randWordAddr();
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            typ = k % 3;
            a0 = randWordAddr() | 32'($urandom_range(0, 3));
            wd = $urandom;
            case (typ)
                0:       driveReq(1, 0, 1'b1, 1'b0, 4'($urandom_range(0, 15)), a0, wd);
                1:       driveReq(1, 0, 1'b1, 1'b1, 4'hF, a0, wd);
                default: driveReq(1, 0, 1'b1, 1'b1, 4'h0, a0, wd);
            endcase
            driveReq(1, 1, 1'b1, 1'b0, 4'hF, a1, 32'h0);
            eD = (typ == 0) ? refB[a0[5:2]] : 32'h0;
            #1;
            checks++;
            if (busB.req_ready !== 2'b01) begin
                errors++; $display("[TB] FAIL fp_grant k=%0d got %b want 01", k, busB.req_ready);
            end
            checks++;
            if (typ == 0 && (busB.mem_read_en !== 1'b1 || busB.mem_wr_en !== 1'b0 ||
                             busB.mem_address !== {a0[31:2], 2'b00})) begin
                errors++; $display("[TB] FAIL fp_load k=%0d got re=%b we=%b a=%h", k, busB.mem_read_en, busB.mem_wr_en, busB.mem_address);
            end else if (typ == 1 && (busB.mem_wr_en !== 1'b1 || busB.mem_read_en !== 1'b0 ||
                                      busB.mem_address !== {a0[31:2], 2'b00} || busB.mem_write_data !== wd)) begin
                errors++; $display("[TB] FAIL fp_store k=%0d got we=%b re=%b a=%h d=%h want d=%h",
                                   k, busB.mem_wr_en, busB.mem_read_en, busB.mem_address, busB.mem_write_data, wd);
            end else if (typ == 2 && ({busB.mem_wr_en, busB.mem_read_en} !== 2'b00 ||
                                      busB.mem_address !== 32'h0 || busB.mem_write_data !== 32'h0)) begin
                errors++; $display("[TB] FAIL fp_be0 k=%0d got we=%b re=%b a=%h d=%h want 0",
                                   k, busB.mem_wr_en, busB.mem_read_en, busB.mem_address, busB.mem_write_data);
            end
            if (typ == 1) refB[a0[5:2]] = wd;
            @(posedge clock); #1;
            checks++;
            if (busB.rsp_valid !== 2'b01 || busB.rsp_rdata[31:0] !== eD) begin
                errors++; $display("[TB] FAIL fp_rsp k=%0d got v=%b d=%h want 01/%h", k, busB.rsp_valid, busB.rsp_rdata[31:0], eD);
            end
        end
        @(negedge clock);
        idleAll();
    endtask

    task automatic test_reset_rmw();
        logic [31:0] orig;
        orig = refA[8];
        driveReq(0, 0, 1'b1, 1'b1, 4'b0001, 32'h20, 32'h00000055);
        #1;
        checks++;
        if (busA.req_ready !== 2'b01 || busA.mem_read_en !== 1'b1) begin
            errors++; $display("[TB] FAIL rr_read got rdy=%b re=%b want 01/1", busA.req_ready, busA.mem_read_en);
        end
        @(posedge clock); #1;
        @(negedge clock);
        reset = 1'b1;
        idleAll();
        #1;
        checks++;
        if (busA.mem_wr_en !== 1'b0 || busA.req_ready !== 2'b00) begin
            errors++; $display("[TB] FAIL rr_abandon got we=%b rdy=%b want 0/00", busA.mem_wr_en, busA.req_ready);
        end
        @(posedge clock); #1;
        checks++;
        if (busA.rsp_valid !== 2'b00 || memA[8] !== orig) begin
            errors++; $display("[TB] FAIL rr_norsp got v=%b mem=%h want 00/%h", busA.rsp_valid, memA[8], orig);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (busA.mem_wr_en !== 1'b0) begin
            errors++; $display("[TB] FAIL rr_after got we=%b want 0", busA.mem_wr_en);
        end
        @(posedge clock); #1;
        checks++;
        if (busA.rsp_valid !== 2'b00 || memA[8] !== orig) begin
            errors++; $display("[TB] FAIL rr_late got v=%b mem=%h want 00/%h", busA.rsp_valid, memA[8], orig);
        end
        @(negedge clock);
    endtask

    // Random traffic: requests are held until accepted; the model tracks memory and expected responses.
    task automatic test_random();
        bit          pend [2];
        logic        pWe  [2];
        logic [3:0]  pBe  [2];
        logic [31:0] pAddr [2];
        logic [31:0] pWd  [2];
        logic [31:0] holdD [2];
        logic [31:0] nD   [2];
        logic [1:0]  nV;
        logic [1:0]  eRdy;
        logic        eWr, eRd;
        logic [31:0] eAddr, eWd, eData;
        bit          lastG;
        bit          rmwLeft;
        int          rmwW, rmwG, g, w;
        logic [31:0] rmwData;
        lastG = 1'b1;
        rmwLeft = 1'b0;
        rmwW = 0; rmwG = 0; rmwData = '0;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0; holdD[r] = 32'h0; pWe[r] = 1'b0; pBe[r] = 4'h0; pAddr[r] = '0; pWd[r] = '0;
        end
        for (int cyc = 0; cyc < 250; cyc++) begin
            if (cyc > 0) @(negedge clock);
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) != 0) begin
                    pend[r]  = 1'b1;
                    pWe[r]   = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 3))
                        0:       pBe[r] = 4'hF;
                        1:       pBe[r] = 4'h0;
                        default: pBe[r] = 4'($urandom_range(1, 14));
                    endcase
                    pAddr[r] = randWordAddr() | 32'($urandom_range(0, 3));
                    pWd[r]   = $urandom;
                end
                driveReq(0, r, pend[r], pWe[r], pBe[r], pAddr[r], pWd[r]);
            end
            eRdy = 2'b00; eWr = 1'b0; eRd = 1'b0; eAddr = 32'h0; eWd = 32'h0;
            g = 0;
            if (rmwLeft) begin
                eWr = 1'b1; eAddr = 32'(rmwW * 4); eWd = rmwData;
            end else if (pend[0] || pend[1]) begin
                if (pend[0] && pend[1]) g = lastG ? 0 : 1;
                else g = pend[0] ? 0 : 1;
                eRdy = (g == 0) ? 2'b01 : 2'b10;
                if (!pWe[g] || pBe[g] != 4'h0) eAddr = {pAddr[g][31:2], 2'b00};
                if (!pWe[g]) eRd = 1'b1;
                else if (pBe[g] == 4'hF) begin eWr = 1'b1; eWd = pWd[g]; end
                else if (pBe[g] != 4'h0) eRd = 1'b1;
            end
            #1;
            checks++;
            if (busA.req_ready !== eRdy) begin
                errors++; $display("[TB] FAIL rand_ready cyc=%0d got %b want %b", cyc, busA.req_ready, eRdy);
            end
            checks++;
            if (busA.mem_wr_en !== eWr || busA.mem_read_en !== eRd || busA.mem_address !== eAddr ||
                busA.mem_write_data !== eWd) begin
                errors++; $display("[TB] FAIL rand_mem cyc=%0d got we=%b re=%b a=%h d=%h want %b/%b/%h/%h",
                                   cyc, busA.mem_wr_en, busA.mem_read_en, busA.mem_address, busA.mem_write_data,
                                   eWr, eRd, eAddr, eWd);
            end
            nV = 2'b00; nD[0] = 32'h0; nD[1] = 32'h0;
            if (rmwLeft) begin
                refA[rmwW] = rmwData;
                nV[rmwG] = 1'b1;
                rmwLeft = 1'b0;
            end else if (eRdy != 2'b00) begin
                lastG = (g == 1);
                pend[g] = 1'b0;
                w = int'(pAddr[g][5:2]);
                if (!pWe[g]) begin
                    nV[g] = 1'b1; nD[g] = refA[w];
                end else if (pBe[g] == 4'hF) begin
                    refA[w] = pWd[g]; nV[g] = 1'b1;
                end else if (pBe[g] == 4'h0) begin
                    nV[g] = 1'b1;
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        rmwData[8*b +: 8] = pBe[g][b] ? pWd[g][8*b +: 8] : refA[w][8*b +: 8];
                    end
                    rmwW = w; rmwG = g; rmwLeft = 1'b1;
                end
            end
            @(posedge clock); #1;
            checks++;
            if (busA.rsp_valid !== nV) begin
                errors++; $display("[TB] FAIL rand_rspv cyc=%0d got %b want %b", cyc, busA.rsp_valid, nV);
            end
            for (int r = 0; r < 2; r++) begin
                if (nV[r]) holdD[r] = nD[r];
                eData = holdD[r];
                checks++;
                if (busA.rsp_rdata[r*32 +: 32] !== eData) begin
                    errors++; $display("[TB] FAIL rand_rdata cyc=%0d req=%0d got %h want %h",
                                       cyc, r, busA.rsp_rdata[r*32 +: 32], eData);
                end
            end
        end
        @(negedge clock);
        idleAll();
    endtask

    initial begin
        @(posedge clock); #1 memInit = 1'b0;
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            initA[i] = $urandom;
            initB[i] = $urandom;
            refA[i]  = initA[i];
            refB[i]  = initB[i];
        end
        idleAll();
        busA.req_valid = 2'b00;
        test_reset();
        test_alternate();
        test_store_load();
        test_rmw();
        test_fixed_priority();
        test_reset_rmw();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
